// File: rtl/imem_port_arbiter_pkg.sv
`default_nettype none
//==============================================================================
// Module      : imem_port_arbiter_pkg
// Description : Instruction-memory constants and arbiter state encoding.
// Revision    : 1.0 - initial release
//==============================================================================
package imem_port_arbiter_pkg;

    localparam int WORD_SIZE       = 19;
    localparam int IMEM_ADDR_W     = 10;
    localparam int IMEM_MAX_STREAK = 4;

    typedef enum logic [0:0] {
        IMEM_IDLE    = 1'b0,
        IMEM_RD_WAIT = 1'b1
    } imem_arb_state_e;

endpackage : imem_port_arbiter_pkg
`default_nettype wire

// File: rtl/imem_port_arbiter_if.sv
`default_nettype none
//==============================================================================
// Module      : imem_port_arbiter_if
// Description : Fetch, loader and memory-side signals of the imem arbiter.
// Revision    : 1.0 - initial release
//==============================================================================
interface imem_port_arbiter_if
    import imem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter int DATA_W = WORD_SIZE
) ();

    logic              fetch_req_valid;
    logic              fetch_req_ready;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_rsp_valid;
    logic              fetch_rsp_ready;
    logic [DATA_W-1:0] fetch_rsp_data;
    logic              load_req_valid;
    logic              load_req_ready;
    logic [ADDR_W-1:0] load_addr;
    logic [DATA_W-1:0] load_data;
    logic              mem_rd_en;
    logic              mem_wr_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    // Arbiter side
    modport slave (
        input  fetch_req_valid, fetch_addr, fetch_rsp_ready,
        input  load_req_valid, load_addr, load_data, mem_rdata,
        output fetch_req_ready, fetch_rsp_valid, fetch_rsp_data,
        output load_req_ready, mem_rd_en, mem_wr_en, mem_addr, mem_wdata, busy
    );

    // Requester / memory side
    modport master (
        output fetch_req_valid, fetch_addr, fetch_rsp_ready,
        output load_req_valid, load_addr, load_data, mem_rdata,
        input  fetch_req_ready, fetch_rsp_valid, fetch_rsp_data,
        input  load_req_ready, mem_rd_en, mem_wr_en, mem_addr, mem_wdata, busy
    );

endinterface : imem_port_arbiter_if
`default_nettype wire

// File: rtl/imem_port_arbiter_rsp_reg.sv
`default_nettype none
//==============================================================================
// Module      : imem_rsp_reg
// Description : Capture/hold response register with valid/ready output.
// Revision    : 1.0 - initial release
//==============================================================================
module imem_rsp_reg #(
    parameter int DATA_W = 19
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_capture,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;

    // Capture wins over consume; the arbiter never lets both happen together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_capture) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule : imem_rsp_reg
`default_nettype wire

// File: rtl/imem_port_arbiter.sv
`default_nettype none
//==============================================================================
// Module      : imem_port_arbiter
// Description : Single-port instruction-memory arbiter between fetch reads and
//               loader writes, with bounded loader starvation.
// Revision    : 1.0 - initial release
//==============================================================================
module imem_port_arbiter
    import imem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = IMEM_ADDR_W,
    parameter int DATA_W     = WORD_SIZE,
    parameter int MAX_STREAK = IMEM_MAX_STREAK
) (
    input  logic               CLK,
    input  logic               RESET,
    imem_port_arbiter_if.slave bus
);

    localparam int                    c_STREAK_W   = $clog2(MAX_STREAK + 1);
    localparam logic [c_STREAK_W-1:0] c_STREAK_MAX = c_STREAK_W'(MAX_STREAK);

    imem_arb_state_e       r_state;
    imem_arb_state_e       w_state_nxt;
    logic [c_STREAK_W-1:0] r_streak;
    logic                  w_rsp_valid;
    logic [DATA_W-1:0]     w_rsp_data;
    logic                  w_fetch_elig;
    logic                  w_streak_full;
    logic                  w_fetch_grant;
    logic                  w_load_grant;
    logic                  w_capture;
    logic [ADDR_W-1:0]     w_mem_addr;
    logic [DATA_W-1:0]     w_mem_wdata;

    // Only one read outstanding: the response slot must be free or freeing now.
    assign w_fetch_elig  = !w_rsp_valid || bus.fetch_rsp_ready;
    assign w_streak_full = (r_streak == c_STREAK_MAX);
    assign w_capture     = (r_state == IMEM_RD_WAIT);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= IMEM_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_fetch_grant = 1'b0;
        w_load_grant  = 1'b0;
        case (r_state)
            IMEM_IDLE: begin
                if (w_fetch_elig && bus.fetch_req_valid &&
                    !(bus.load_req_valid && w_streak_full)) begin
                    w_fetch_grant = 1'b1;
                    w_state_nxt   = IMEM_RD_WAIT;
                end
                w_load_grant = bus.load_req_valid && !w_fetch_grant;
            end
            IMEM_RD_WAIT: begin
                w_state_nxt  = IMEM_IDLE;
                w_load_grant = bus.load_req_valid;
            end
        endcase
        if (RESET) begin
            w_fetch_grant = 1'b0;
            w_load_grant  = 1'b0;
        end
    end

    // Loads slotted into RD_WAIT leave the streak alone, so the contested IDLE
    // slots still follow the fetch-streak/load pattern.
    always_ff @(posedge CLK) begin
        if (RESET || !bus.load_req_valid) begin
            r_streak <= '0;
        end else if (w_load_grant && (r_state == IMEM_IDLE)) begin
            r_streak <= '0;
        end else if (w_fetch_grant && !w_streak_full) begin
            r_streak <= r_streak + 1'b1;
        end
    end

    always_comb begin
        w_mem_addr  = '0;
        w_mem_wdata = '0;
        if (w_fetch_grant) begin
            w_mem_addr = bus.fetch_addr;
        end else if (w_load_grant) begin
            w_mem_addr  = bus.load_addr;
            w_mem_wdata = bus.load_data;
        end
    end

    imem_rsp_reg #(
        .DATA_W (DATA_W)
    ) u_rsp_reg (
        .clk       (CLK),
        .rst       (RESET),
        .i_capture (w_capture),
        .i_data    (bus.mem_rdata),
        .i_ready   (bus.fetch_rsp_ready),
        .o_valid   (w_rsp_valid),
        .o_data    (w_rsp_data)
    );

    assign bus.fetch_req_ready = w_fetch_grant;
    assign bus.load_req_ready  = w_load_grant;
    assign bus.mem_rd_en       = w_fetch_grant;
    assign bus.mem_wr_en       = w_load_grant;
    assign bus.mem_addr        = w_mem_addr;
    assign bus.mem_wdata       = w_mem_wdata;
    assign bus.fetch_rsp_valid = w_rsp_valid;
    assign bus.fetch_rsp_data  = w_rsp_data;
    assign bus.busy            = (r_state == IMEM_RD_WAIT) || w_rsp_valid;

endmodule : imem_port_arbiter
`default_nettype wire
